// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter in front of the interconnect's single master port.
// Master 0 is the CPU core, master 1 the debug engine (or a later DMA engine).
// A grant is held for the whole bus cycle (cyc). A strobe that is never
// acknowledged is aborted after TIMEOUT cycles with a one-cycle error pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | no owner; s_cyc_o/s_stb_o low; arbitrate requests pending on cyc
// GNT0     | master 0 owns the bus; its signals are muxed onto the s_ port
// GNT1     | master 1 owns the bus; its signals are muxed onto the s_ port
// ABORT    | one-cycle timeout abort; bus released; owner sees err_o
module wb_arbiter2 #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int SEL_WIDTH  = 2,
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // master 0
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   input  logic [SEL_WIDTH-1:0]  m0_sel_i,
   input  logic                  m0_we_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   // master 1
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   input  logic [SEL_WIDTH-1:0]  m1_sel_i,
   input  logic                  m1_we_i,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   // interconnect side
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   output logic [SEL_WIDTH-1:0]  s_sel_o,
   output logic                  s_we_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   input  logic                  s_ack_i,
   // current grant, one-hot, bit0 = master 0
   output logic [1:0]            gnt_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT0  = 2'd1;
   localparam logic [1:0] ST_GNT1  = 2'd2;
   localparam logic [1:0] ST_ABORT = 2'd3;

   // A zero TIMEOUT still needs a legal one-bit counter; it is simply never used.
   localparam bit              TO_EN  = (TIMEOUT > 0);
   localparam int              CNT_W  = TO_EN ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   // last doubles as the owner of the current grant: it is written on every
   // grant entry, so during ABORT it still names the offending master.
   logic             last;
   logic             last_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   logic granted;
   logic sel_cyc;
   logic sel_stb;
   logic stalled;
   logic timeout_hit;

   assign granted = (state == ST_GNT0) || (state == ST_GNT1);

   // Control signals of whichever master currently owns the bus.
   always_comb begin
      sel_cyc = 1'b0;
      sel_stb = 1'b0;
      if (state == ST_GNT0) begin
         sel_cyc = m0_cyc_i;
         sel_stb = m0_stb_i;
      end else if (state == ST_GNT1) begin
         sel_cyc = m1_cyc_i;
         sel_stb = m1_stb_i;
      end
   end

   // An ack on the terminal cycle masks the timeout, so ack always wins.
   assign stalled     = granted && sel_stb && !s_ack_i;
   assign timeout_hit = TO_EN && stalled && (cnt == CNT_TC);

   // Next-state and round-robin pointer update.
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      case (state)
         ST_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               if ((FIXED_PRIO != 0) || last) begin
                  state_nxt = ST_GNT0;
                  last_nxt  = 1'b0;
               end else begin
                  state_nxt = ST_GNT1;
                  last_nxt  = 1'b1;
               end
            end else if (m0_cyc_i) begin
               state_nxt = ST_GNT0;
               last_nxt  = 1'b0;
            end else if (m1_cyc_i) begin
               state_nxt = ST_GNT1;
               last_nxt  = 1'b1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (!sel_cyc) begin
               state_nxt = ST_IDLE;
            end else if (timeout_hit) begin
               state_nxt = ST_ABORT;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Stall counter: counts un-acked strobe cycles of the owner, holds at the
   // terminal value (ABORT follows immediately) and clears whenever the grant ends.
   always_comb begin
      cnt_nxt = '0;
      if (TO_EN && stalled && (state_nxt == state)) begin
         if (cnt == CNT_TC) begin
            cnt_nxt = cnt;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Interconnect port is a pure mux of the owner; everything is quiet otherwise.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (state == ST_GNT0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_sel_o = m0_sel_i;
         s_we_o  = m0_we_i;
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i;
      end else if (state == ST_GNT1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_sel_o = m1_sel_i;
         s_we_o  = m1_we_i;
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i;
      end
   end

   // Grant decode from registered state only, so no cyc-to-gnt combinational path.
   always_comb begin
      gnt_o = 2'b00;
      case (state)
         ST_GNT0:  gnt_o = 2'b01;
         ST_GNT1:  gnt_o = 2'b10;
         ST_ABORT: gnt_o = last ? 2'b10 : 2'b01;
         default:  gnt_o = 2'b00;
      endcase
   end

   // Return path: data is broadcast, ack/err are steered to the owner only.
   always_comb begin
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      m0_ack_o = (state == ST_GNT0) && s_ack_i && m0_stb_i;
      m1_ack_o = (state == ST_GNT1) && s_ack_i && m1_stb_i;
      m0_err_o = (state == ST_ABORT) && !last;
      m1_err_o = (state == ST_ABORT) && last;
   end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed stimulus with a scoreboard of expected
// ack/err events checked by an independent monitor, plus direct grant checks.
module tb_wb_arbiter2;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // main DUT: round-robin, TIMEOUT=8
   logic [31:0] m0_adr = '0, m1_adr = '0;
   logic [15:0] m0_wdat = '0, m1_wdat = '0;
   logic [1:0]  m0_sel = 2'b11, m1_sel = 2'b11;
   logic        m0_we = 0, m0_cyc = 0, m0_stb = 0;
   logic        m1_we = 0, m1_cyc = 0, m1_stb = 0;
   logic [15:0] m0_rdat, m1_rdat;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] s_adr;
   logic [15:0] s_wdat;
   logic [1:0]  s_sel;
   logic        s_we, s_cyc, s_stb;
   logic [15:0] s_rdat = '0;
   logic        s_ack = 1'b0;
   logic [1:0]  gnt;

   wb_arbiter2 #(.FIXED_PRIO(0), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_rdat), .s_ack_i(s_ack),
      .gnt_o(gnt)
   );

   // second DUT: fixed priority
   logic        fp_m0_cyc = 0, fp_m0_stb = 0, fp_m1_cyc = 0, fp_m1_stb = 0;
   logic        fp_s_ack = 1'b0;
   logic [15:0] fp_m0_rdat, fp_m1_rdat, fp_s_wdat;
   logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
   logic [31:0] fp_s_adr;
   logic [1:0]  fp_s_sel, fp_gnt;
   logic        fp_s_we, fp_s_cyc, fp_s_stb;

   wb_arbiter2 #(.FIXED_PRIO(1), .TIMEOUT(8)) dut_fp (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_adr_i(32'h0000_0010), .m0_dat_i(16'h0), .m0_sel_i(2'b11), .m0_we_i(1'b0),
      .m0_cyc_i(fp_m0_cyc), .m0_stb_i(fp_m0_stb), .m0_dat_o(fp_m0_rdat),
      .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
      .m1_adr_i(32'h0000_0020), .m1_dat_i(16'h0), .m1_sel_i(2'b11), .m1_we_i(1'b0),
      .m1_cyc_i(fp_m1_cyc), .m1_stb_i(fp_m1_stb), .m1_dat_o(fp_m1_rdat),
      .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
      .s_adr_o(fp_s_adr), .s_dat_o(fp_s_wdat), .s_sel_o(fp_s_sel), .s_we_o(fp_s_we),
      .s_cyc_o(fp_s_cyc), .s_stb_o(fp_s_stb), .s_dat_i(16'h0), .s_ack_i(fp_s_ack),
      .gnt_o(fp_gnt)
   );

   typedef struct packed {
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [1:0]  gnt;
      logic [15:0] dat;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic push(input logic [1:0] ack, input logic [1:0] err,
                       input logic [1:0] g, input logic [15:0] d);
      exp_t e;
      e.ack = ack;
      e.err = err;
      e.gnt = g;
      e.dat = d;
      sb_q.push_back(e);
   endtask

   // Monitor: every ack/err the main DUT presents must match the next expected event.
   always @(negedge clk_i) begin
      if (rst_i && (m0_ack || m1_ack || m0_err || m1_err)) begin
         exp_t e;
         logic [15:0] d;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event ack=%b err=%b gnt=%b t=%0t",
                     {m1_ack, m0_ack}, {m1_err, m0_err}, gnt, $time);
         end else begin
            e = sb_q.pop_front();
            d = m0_ack ? m0_rdat : m1_rdat;
            if ({m1_ack, m0_ack} !== e.ack || {m1_err, m0_err} !== e.err ||
                gnt !== e.gnt || ((e.ack != 2'b00) && (d !== e.dat))) begin
               errors++;
               $display("FAIL sb_event got ack=%b err=%b gnt=%b dat=%h exp ack=%b err=%b gnt=%b dat=%h t=%0t",
                        {m1_ack, m0_ack}, {m1_err, m0_err}, gnt, d,
                        e.ack, e.err, e.gnt, e.dat, $time);
            end
         end
      end
   end

   task automatic set_req(input bit fp, input bit m, input logic v);
      if (fp) begin
         if (m) begin fp_m1_cyc = v; fp_m1_stb = v; end
         else   begin fp_m0_cyc = v; fp_m0_stb = v; end
      end else begin
         if (m) begin m1_cyc = v; m1_stb = v; end
         else   begin m0_cyc = v; m0_stb = v; end
      end
   endtask

   function automatic logic [1:0] gnt_of(input bit fp);
      return fp ? fp_gnt : gnt;
   endfunction

   // Both masters request together; the winner does one beat, drops cyc for a
   // cycle and re-requests in the IDLE gap. seq holds expected one-hot grants.
   task automatic tie_run(input bit fp, input int n, input logic [7:0] seq);
      logic [1:0] t;
      bit         tm;
      step();
      set_req(fp, 1'b0, 1'b1);
      set_req(fp, 1'b1, 1'b1);
      for (int i = 0; i < n; i++) begin
         t  = seq[2*i +: 2];
         tm = t[1];
         step();
         if (fp) begin
            fp_s_ack = 1'b1;
         end else begin
            s_ack  = 1'b1;
            s_rdat = 16'hA000 + 16'(i);
            push(t, 2'b00, t, 16'hA000 + 16'(i));
         end
         sample();
         check(fp ? "fp_tie_gnt" : "rr_tie_gnt", gnt_of(fp), t);
         if (fp) check("fp_tie_ack", {fp_m1_ack, fp_m0_ack}, t);
         step();
         s_ack    = 1'b0;
         fp_s_ack = 1'b0;
         set_req(fp, tm, 1'b0);
         step();
         if (i < n - 1) begin
            set_req(fp, tm, 1'b1);
         end else begin
            set_req(fp, 1'b0, 1'b0);
            set_req(fp, 1'b1, 1'b0);
         end
         sample();
         check(fp ? "fp_tie_idle_gap" : "rr_tie_idle_gap", gnt_of(fp), 2'b00);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #2;
      check("rst_gnt", gnt, 2'b00);
      check("rst_s_ctl", {s_cyc, s_stb, s_we}, 3'b000);
      check("rst_ack_err", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
      check("rst_fp_gnt", fp_gnt, 2'b00);
      #20 rst_i = 1'b1;

      // single master read
      step();
      m0_adr = 32'h0000_1000; m0_we = 1'b0; set_req(0, 1'b0, 1'b1);
      sample();
      check("rd_arb_latency", gnt, 2'b00);
      step();
      sample();
      check("rd_gnt", gnt, 2'b01);
      check("rd_s_adr", s_adr, 32'h0000_1000);
      check("rd_s_cyc_stb", {s_cyc, s_stb}, 2'b11);
      step();
      step();
      s_ack = 1'b1; s_rdat = 16'hBEEF;
      push(2'b01, 2'b00, 2'b01, 16'hBEEF);
      step();
      s_ack = 1'b0; set_req(0, 1'b0, 1'b0);
      step();
      sample();
      check("rd_done_idle", gnt, 2'b00);

      // async reset in the middle of an m0 write
      step();
      m0_adr = 32'h0000_2000; m0_wdat = 16'h1234; m0_we = 1'b1; set_req(0, 1'b0, 1'b1);
      step();
      sample();
      check("ar_pre_gnt", gnt, 2'b01);
      check("ar_pre_s_ctl", {s_cyc, s_stb, s_we}, 3'b111);
      #2 rst_i = 1'b0;
      #1;
      check("ar_gnt_now", gnt, 2'b00);
      check("ar_s_cyc_stb_now", {s_cyc, s_stb}, 2'b00);
      set_req(0, 1'b0, 1'b0); m0_we = 1'b0;
      #6 rst_i = 1'b1;

      // round-robin tie: m0 first after reset
      tie_run(1'b0, 4, 8'b10_01_10_01);
      // fixed priority tie
      tie_run(1'b1, 3, 8'b00_01_01_01);

      // bus lock: m0 four beats while m1 requests
      step();
      m0_adr = 32'h3000_0000; m0_we = 1'b0; set_req(0, 1'b0, 1'b1);
      step();
      m1_adr = 32'hF000_0100; m1_wdat = 16'hCAFE; m1_we = 1'b1; set_req(0, 1'b1, 1'b1);
      s_ack = 1'b1; s_rdat = 16'h5000;
      push(2'b01, 2'b00, 2'b01, 16'h5000);
      sample();
      check("lock_gnt_0", gnt, 2'b01);
      check("lock_adr_0", s_adr, 32'h3000_0000);
      for (int k = 1; k < 4; k++) begin
         step();
         m0_adr = 32'h3000_0000 + 32'(2 * k);
         s_rdat = 16'h5000 + 16'(k);
         push(2'b01, 2'b00, 2'b01, 16'h5000 + 16'(k));
         sample();
         check("lock_gnt", gnt, 2'b01);
         check("lock_adr", s_adr, 32'h3000_0000 + 32'(2 * k));
      end
      step();
      s_ack = 1'b0; set_req(0, 1'b0, 1'b0);
      sample();
      check("lock_release_s_cyc", s_cyc, 1'b0);
      step();
      sample();
      check("lock_idle", gnt, 2'b00);

      // timeout: m1 write never acked
      step();
      sample();
      check("to_m1_gnt", gnt, 2'b10);
      check("to_s_adr", s_adr, 32'hF000_0100);
      check("to_s_we", s_we, 1'b1);
      for (int k = 1; k < 8; k++) step();
      sample();
      check("to_still_cyc", s_cyc, 1'b1);
      push(2'b00, 2'b10, 2'b10, 16'h0000);
      step();
      sample();
      check("to_abort_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
      check("to_abort_gnt", gnt, 2'b10);
      step();
      set_req(0, 1'b1, 1'b0);
      sample();
      check("to_back_idle", gnt, 2'b00);

      // ack on the terminal cycle wins over the timeout
      step();
      set_req(0, 1'b1, 1'b1);
      step();
      sample();
      check("tack_gnt", gnt, 2'b10);
      for (int k = 1; k < 8; k++) step();
      s_ack = 1'b1; s_rdat = 16'h7777;
      push(2'b10, 2'b00, 2'b10, 16'h7777);
      step();
      s_ack = 1'b0; set_req(0, 1'b1, 1'b0); m1_we = 1'b0;
      sample();
      check("tack_no_abort", gnt, 2'b10);
      step();
      sample();
      check("tack_idle", gnt, 2'b00);

      // back-to-back same master
      step();
      m0_adr = 32'h0000_4000; m0_wdat = 16'h1111; m0_we = 1'b1; set_req(0, 1'b0, 1'b1);
      step();
      s_ack = 1'b1; s_rdat = 16'h2222;
      push(2'b01, 2'b00, 2'b01, 16'h2222);
      sample();
      check("b2b_gnt_1", gnt, 2'b01);
      step();
      s_ack = 1'b0; set_req(0, 1'b0, 1'b0);
      step();
      set_req(0, 1'b0, 1'b1);
      sample();
      check("b2b_idle_gnt", gnt, 2'b00);
      check("b2b_idle_s_ctl", {s_cyc, s_stb, s_we}, 3'b000);
      step();
      s_ack = 1'b1; s_rdat = 16'h3333;
      push(2'b01, 2'b00, 2'b01, 16'h3333);
      sample();
      check("b2b_gnt_2", gnt, 2'b01);
      step();
      s_ack = 1'b0; set_req(0, 1'b0, 1'b0); m0_we = 1'b0;
      step();
      step();
      sample();
      check("b2b_end_idle", gnt, 2'b00);
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master Wishbone arbiter that shares the single master port of the SoC bus interconnect.
- Master 0 is the moxielite core; master 1 is the gdb debug/target engine or a future DMA engine.
- Grants one master at a time, holds the grant for a whole cycle (cyc), and aborts stuck transfers with a timeout error.
- Sits between the masters and the interconnect's wbm_* port.

Parameters:
- DATA_WIDTH, 16, Wishbone data width.
- ADDR_WIDTH, 32, Wishbone address width.
- SEL_WIDTH, 2, byte-select width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = master 0 always wins a simultaneous request.
- TIMEOUT, 255, cycles of stb without ack before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_adr_i / m1_adr_i  in  ADDR_WIDTH  master address.
- m0_dat_i / m1_dat_i  in  DATA_WIDTH  master write data.
- m0_sel_i / m1_sel_i  in  SEL_WIDTH  master byte selects.
- m0_we_i, m0_cyc_i, m0_stb_i / m1_we_i, m1_cyc_i, m1_stb_i  in  1 each  master control.
- m0_dat_o / m1_dat_o  out  DATA_WIDTH  read data; both driven from s_dat_i.
- m0_ack_o / m1_ack_o  out  1  acknowledge.
- m0_err_o / m1_err_o  out  1  timeout error.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  (widths as above)  to interconnect.
- s_dat_i  in  DATA_WIDTH  read data from interconnect.
- s_ack_i  in  1  acknowledge from interconnect.
- gnt_o  out  2  one-hot current grant; bit0 = master 0.

Behaviour:
- **FSM states:** IDLE, GNT0, GNT1, ABORT.
- **Reset (rst_i low, asynchronous):**
  - State goes to IDLE; gnt_o = 2'b00.
  - s_cyc_o, s_stb_o, s_we_o, all ack_o and err_o = 0 immediately.
  - Timeout counter = 0; round-robin pointer last = 1, so master 0 wins the first tie.
- **IDLE:**
  - No s_cyc_o/s_stb_o.
  - If exactly one mN_cyc_i is high, go to GNTN next edge.
  - If both are high: with FIXED_PRIO=1 go to GNT0; otherwise go to the master not equal to last.
  - Entering GNTN sets last = N.
  - Arbitration latency is 1 cycle from cyc assertion to grant.
- **GNTN:**
  - s_adr/dat/sel/we/cyc/stb are combinationally muxed from master N.
  - mN_ack_o = s_ack_i & mN_stb_i.
  - The other master's ack_o and err_o are held at 0.
  - gnt_o bit N = 1.
  - Grant holds across any number of stb beats while mN_cyc_i stays high (bus lock; no preemption).
  - When mN_cyc_i drops, go to IDLE. s_cyc_o falls in the same cycle because it is muxed.
  - One dead IDLE cycle always separates consecutive grants, including back-to-back requests from the same master.
- **Timeout (TIMEOUT>0):**
  - Counter increments each cycle in GNTN with mN_stb_i=1 and s_ack_i=0.
  - Counter clears on s_ack_i, on stb low, and on entering IDLE.
  - When counter == TIMEOUT-1 and no ack that cycle, go to ABORT.
- **ABORT:**
  - One cycle long. s_cyc_o = s_stb_o = 0.
  - Offending mN_err_o = 1 for exactly this cycle; ack_o = 0; gnt_o keeps bit N.
  - Next state is IDLE. The master is expected to drop cyc; if it does not, it re-arbitrates as a new request.
- **Simultaneous ack and timeout edge:** ack wins; no error; counter clears.
- Counter width is clog2(TIMEOUT+1) and it never wraps: it saturates at its terminal value because ABORT follows.
- The non-granted master's request is simply stalled: no ack, no err. Wishbone requires it to keep cyc/stb asserted.
- No combinational path from any m*_cyc_i to gnt_o; gnt_o is decoded from registered state.

Test Plan:
- **Single master read:** reset, m0 cyc/stb, adr=0x00001000, ack after 2 cycles, s_dat_i=0xBEEF.
  - gnt_o=01 one cycle after cyc; m0_ack_o pulses once; m0_dat_o=0xBEEF; m1_ack_o stays 0.
- **Round-robin tie:** both masters assert cyc in the same cycle, 1-beat transfers, then both re-request.
  - Grant order m0, m1, m0, m1; one IDLE cycle between grants.
  - FIXED_PRIO=1 gives m0, m0, m0.
- **Bus lock:** m0 holds cyc over 4 stb beats to 0x30000000–0x30000006 while m1 requests.
  - gnt_o stays 01 through all 4 acks; m1 is granted only after m0 drops cyc.
- **Timeout:** TIMEOUT=8; m1 writes to 0xF0000100 and the interconnect never acks.
  - m1_err_o high for exactly 1 cycle, 8 cycles after the grant.
  - s_cyc_o low in that cycle; FSM returns to IDLE.
  - An ack arriving on cycle 8 instead produces ack and no err.
- **Async reset mid-transfer:** pull rst_i low during an m0 write with stb high, asynchronously to clk_i.
  - s_cyc_o, s_stb_o and gnt_o go 0 without waiting for an edge.
  - After release, m0 wins the first tie.
- **Back-to-back same master:** m0 drops cyc for 1 cycle then reasserts with m1 idle.
  - Regranted after one IDLE cycle.
  - No spurious ack, and we is never visible on the s_ port during IDLE.
